sdram_wr_arbiter: RTL and testbench
===================================

// Module: sdram_wr_arbiter
// PURPOSE
//   Shares one Avalon-MM SDRAM write port (f2h_sdram) between two burst write masters
//   (e.g. two frame writers) in the clk_200 domain. Grants whole bursts: once a master
//   is granted, it owns the port until all burstcount beats are accepted. Sits between
//   the frame writers and the HPS SDRAM bridge; round-robin or fixed priority.
// PARAMETERS
//   DATA_W      64   writedata width
//   ADDR_W      29   word address width
//   BURST_W     8    burstcount width
//   PRIO_FIXED  0    0 = round-robin, 1 = master 0 always wins a tie
// PORTS
//   clk_200           in   1        system clock (200 MHz)
//   reset             in   1        synchronous, active-high reset
//   m0_write          in   1        master 0 write request / beat valid
//   m0_address        in   ADDR_W   master 0 burst start address (sampled on first beat)
//   m0_writedata      in   DATA_W   master 0 write data
//   m0_burstcount     in   BURST_W  master 0 burst length (sampled at grant)
//   m0_waitrequest    out  1        stall to master 0
//   m1_*              -    -        identical set for master 1
//   s_write           out  1        to SDRAM port
//   s_address         out  ADDR_W   to SDRAM port
//   s_writedata       out  DATA_W   to SDRAM port
//   s_burstcount      out  BURST_W  to SDRAM port
//   s_byteenable      out  DATA_W/8 all ones
//   s_waitrequest     in   1        from SDRAM port
//   grant             out  2        one-hot current owner, 2'b00 when idle
//   busy              out  1        state == BURST
//   err_zero_burst    out  1        sticky: a burst with burstcount==0 was granted
//   bursts_m0/m1      out  16 each  completed bursts per master, saturating at 16'hFFFF
// BEHAVIOUR
//   Reset: state IDLE, grant=0, busy=0, s_write=0, m*_waitrequest=1, err_zero_burst=0,
//     bursts_m*=0, RR pointer = master 0 preferred. Reset mid-burst aborts it immediately.
//   FSM IDLE: all m*_waitrequest=1, s_write=0. If any m*_write=1 this cycle, pick winner
//     (one request -> it; both -> PRIO_FIXED ? m0 : RR-preferred), register grant,
//     latch beats_left = burstcount (0 -> load 1, set err_zero_burst), go BURST.
//     Arbitration latency: 1 cycle; first beat can transfer the cycle after entry.
//   FSM BURST: s_write/s_address/s_writedata/s_burstcount = granted master's inputs
//     (combinational mux, no added latency); s_burstcount is forced to the latched value
//     (1 if latched as 0). granted m_waitrequest = s_waitrequest; other = 1.
//     Beat accepted when s_write & !s_waitrequest -> beats_left -= 1.
//     Acceptance with beats_left==1: burst done -> increment granted bursts_m* (saturate),
//     RR pointer -> the other master, grant=0, go IDLE (one-cycle bubble, mandatory).
//   Granted master deasserting write mid-burst: s_write=0, arbiter holds grant and waits
//     (no timeout); the other master stays stalled.
//   s_byteenable constant all ones. Grant never changes in BURST.
//   beats_left width BURST_W; no wrap possible since load value <= 2^BURST_W-1.
// TESTING
//   1. Only m0, burstcount=32, s_waitrequest=0 -> grant=01 one cycle after m0_write, 32
//      beats on s_*, return to IDLE, bursts_m0=1, m1_waitrequest=1 throughout.
//   2. m0 and m1 both request continuously, bc=4, RR -> grants 01,10,01,10 alternating,
//      one idle cycle between bursts, 4 beats each, bursts_m0==bursts_m1 after 8 bursts.
//   3. PRIO_FIXED=1, both request continuously -> m0 granted every burst, bursts_m1=0.
//   4. bc=8, s_waitrequest high on beats 3 and 6 for 2 cycles each -> data held, exactly
//      8 accepted beats, m0_waitrequest mirrors s_waitrequest, no beat duplicated/lost.
//   5. m1 grants with bc=0 -> s_burstcount=1, single beat, err_zero_burst=1 and stays 1.
//   6. reset asserted after beat 10 of a 32-beat burst -> next cycle s_write=0, grant=0,
//      bursts_m*=0; fresh m0 request afterwards is granted normally.

Source files
------------

// File: rtl/sdram_wr_arbiter.sv
// Two-master burst write arbiter for one Avalon-MM SDRAM write port.
// Whole bursts are granted (round-robin or fixed priority) with a one-cycle bubble between owners.
module sdram_wr_arbiter #(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 29,
   parameter int BURST_W    = 8,
   parameter int PRIO_FIXED = 0
) (
   input  logic                clk_200,
   input  logic                reset,
   input  logic                m0_write,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [BURST_W-1:0]  m0_burstcount,
   output logic                m0_waitrequest,
   input  logic                m1_write,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [BURST_W-1:0]  m1_burstcount,
   output logic                m1_waitrequest,
   output logic                s_write,
   output logic [ADDR_W-1:0]   s_address,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [BURST_W-1:0]  s_burstcount,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   output logic [1:0]          grant,
   output logic                busy,
   output logic                err_zero_burst,
   output logic [15:0]         bursts_m0,
   output logic [15:0]         bursts_m1
);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t             state;
   logic [BURST_W-1:0] beats_left;
   logic [BURST_W-1:0] burst_len;
   logic               rr_m1;      // set when master 1 wins the next tie
   logic               pick_m0;
   logic [BURST_W-1:0] pick_bc;
   logic               sel_m1;
   logic               accept;

   always_comb begin
      pick_m0 = m0_write && (!m1_write || (PRIO_FIXED != 0) || !rr_m1);
      pick_bc = pick_m0 ? m0_burstcount : m1_burstcount;
   end

   assign busy           = (state == BURST);
   assign sel_m1         = grant[1];
   assign s_write        = busy && (sel_m1 ? m1_write : m0_write);
   assign s_address      = sel_m1 ? m1_address : m0_address;
   assign s_writedata    = sel_m1 ? m1_writedata : m0_writedata;
   assign s_burstcount   = burst_len;
   assign s_byteenable   = '1;
   assign m0_waitrequest = (busy && grant[0]) ? s_waitrequest : 1'b1;
   assign m1_waitrequest = (busy && grant[1]) ? s_waitrequest : 1'b1;
   assign accept         = s_write && !s_waitrequest;

   always_ff @(posedge clk_200) begin
      if (reset) begin
         state          <= IDLE;
         grant          <= 2'b00;
         beats_left     <= '0;
         burst_len      <= '0;
         rr_m1          <= 1'b0;
         err_zero_burst <= 1'b0;
         bursts_m0      <= '0;
         bursts_m1      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_write || m1_write) begin
                  grant <= pick_m0 ? 2'b01 : 2'b10;
                  // A zero-length burst is carried out as a single beat and flagged.
                  if (pick_bc == '0) begin
                     beats_left     <= BURST_W'(1);
                     burst_len      <= BURST_W'(1);
                     err_zero_burst <= 1'b1;
                  end else begin
                     beats_left <= pick_bc;
                     burst_len  <= pick_bc;
                  end
                  state <= BURST;
               end
            end
            BURST: begin
               if (accept) begin
                  if (beats_left == BURST_W'(1)) begin
                     if (grant[0] && bursts_m0 != 16'hFFFF) bursts_m0 <= bursts_m0 + 16'd1;
                     if (grant[1] && bursts_m1 != 16'hFFFF) bursts_m1 <= bursts_m1 + 16'd1;
                     rr_m1 <= grant[0];
                     grant <= 2'b00;
                     state <= IDLE;
                  end else begin
                     beats_left <= beats_left - BURST_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_wr_arbiter.sv
// Directed bench for sdram_wr_arbiter: a round-robin and a fixed-priority instance share
// the master stimulus; an expected-data queue checks every accepted beat.
module tb_sdram_wr_arbiter;
   localparam int DATA_W  = 64;
   localparam int ADDR_W  = 29;
   localparam int BURST_W = 8;

   logic clk;
   logic reset;
   logic m0_write, m1_write, s_waitrequest;
   logic [ADDR_W-1:0]  m0_address, m1_address;
   logic [DATA_W-1:0]  m0_writedata, m1_writedata;
   logic [BURST_W-1:0] m0_burstcount, m1_burstcount;

   logic ra_m0_wr, ra_m1_wr, ra_s_write, ra_busy, ra_err;
   logic fx_m0_wr, fx_m1_wr, fx_s_write, fx_busy, fx_err;
   logic [ADDR_W-1:0]   ra_addr, fx_addr;
   logic [DATA_W-1:0]   ra_wd, fx_wd;
   logic [BURST_W-1:0]  ra_bc, fx_bc;
   logic [DATA_W/8-1:0] ra_be, fx_be;
   logic [1:0]          ra_grant, fx_grant;
   logic [15:0]         ra_b0, ra_b1, fx_b0, fx_b1;

   bit use_fx;
   logic o_m0_wr, o_m1_wr, o_s_write, o_busy, o_err;
   logic [ADDR_W-1:0]   o_addr;
   logic [DATA_W-1:0]   o_wd;
   logic [BURST_W-1:0]  o_bc;
   logic [DATA_W/8-1:0] o_be;
   logic [1:0]          o_grant;
   logic [15:0]         o_b0, o_b1;

   // values sampled by the most recent step()
   logic g_m0_wr, g_m1_wr, g_s_write, g_busy, g_err;
   logic [ADDR_W-1:0]   g_addr;
   logic [BURST_W-1:0]  g_bc;
   logic [DATA_W/8-1:0] g_be;
   logic [1:0]          g_grant;
   logic [15:0]         g_b0, g_b1;

   int m0_left, m1_left, m0_bc_model, m1_bc_model, acc0, acc1;
   bit m0_rep, m1_rep;
   logic [DATA_W-1:0] exp_q[$];
   int n_checks, n_pass;

   sdram_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .PRIO_FIXED(0)) dut (
      .clk_200(clk), .reset(reset),
      .m0_write(m0_write), .m0_address(m0_address), .m0_writedata(m0_writedata),
      .m0_burstcount(m0_burstcount), .m0_waitrequest(ra_m0_wr),
      .m1_write(m1_write), .m1_address(m1_address), .m1_writedata(m1_writedata),
      .m1_burstcount(m1_burstcount), .m1_waitrequest(ra_m1_wr),
      .s_write(ra_s_write), .s_address(ra_addr), .s_writedata(ra_wd), .s_burstcount(ra_bc),
      .s_byteenable(ra_be), .s_waitrequest(s_waitrequest),
      .grant(ra_grant), .busy(ra_busy), .err_zero_burst(ra_err),
      .bursts_m0(ra_b0), .bursts_m1(ra_b1)
   );

   sdram_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .PRIO_FIXED(1)) dut_fx (
      .clk_200(clk), .reset(reset),
      .m0_write(m0_write), .m0_address(m0_address), .m0_writedata(m0_writedata),
      .m0_burstcount(m0_burstcount), .m0_waitrequest(fx_m0_wr),
      .m1_write(m1_write), .m1_address(m1_address), .m1_writedata(m1_writedata),
      .m1_burstcount(m1_burstcount), .m1_waitrequest(fx_m1_wr),
      .s_write(fx_s_write), .s_address(fx_addr), .s_writedata(fx_wd), .s_burstcount(fx_bc),
      .s_byteenable(fx_be), .s_waitrequest(s_waitrequest),
      .grant(fx_grant), .busy(fx_busy), .err_zero_burst(fx_err),
      .bursts_m0(fx_b0), .bursts_m1(fx_b1)
   );

   always_comb begin
      o_m0_wr   = use_fx ? fx_m0_wr   : ra_m0_wr;
      o_m1_wr   = use_fx ? fx_m1_wr   : ra_m1_wr;
      o_s_write = use_fx ? fx_s_write : ra_s_write;
      o_busy    = use_fx ? fx_busy    : ra_busy;
      o_err     = use_fx ? fx_err     : ra_err;
      o_addr    = use_fx ? fx_addr    : ra_addr;
      o_wd      = use_fx ? fx_wd      : ra_wd;
      o_bc      = use_fx ? fx_bc      : ra_bc;
      o_be      = use_fx ? fx_be      : ra_be;
      o_grant   = use_fx ? fx_grant   : ra_grant;
      o_b0      = use_fx ? fx_b0      : ra_b0;
      o_b1      = use_fx ? fx_b1      : ra_b1;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: sample outputs mid-cycle, score any accepted beat, then advance the master
   // models on the following falling edge.
   task automatic step();
      logic a0, a1;
      logic [DATA_W-1:0] exp;
      #1;
      g_m0_wr = o_m0_wr; g_m1_wr = o_m1_wr; g_s_write = o_s_write; g_busy = o_busy;
      g_err = o_err; g_addr = o_addr; g_bc = o_bc; g_be = o_be; g_grant = o_grant;
      g_b0 = o_b0; g_b1 = o_b1;
      a0 = m0_write && !o_m0_wr;
      a1 = m1_write && !o_m1_wr;
      if (!reset && (a0 || a1)) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL beat_data: got beat %h, want no beat", o_wd);
         end else begin
            exp = exp_q.pop_front();
            if (o_wd !== exp) $display("FAIL beat_data: got %h want %h", o_wd, exp);
            else n_pass++;
         end
      end
      @(negedge clk);
      if (!reset && a0) begin
         acc0++;
         m0_writedata = m0_writedata + 64'd1;
         m0_left--;
         if (m0_left == 0) begin
            if (m0_rep) m0_left = m0_bc_model;
            else m0_write = 1'b0;
         end
      end
      if (!reset && a1) begin
         acc1++;
         m1_writedata = m1_writedata + 64'd1;
         m1_left--;
         if (m1_left == 0) begin
            if (m1_rep) m1_left = m1_bc_model;
            else m1_write = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; m0_write = 1'b0; m1_write = 1'b0; s_waitrequest = 1'b0;
      m0_rep = 0; m1_rep = 0;
      step(); step();
      reset = 1'b0;
      exp_q.delete(); acc0 = 0; acc1 = 0;
   endtask

   task automatic test_reset();
      do_reset();
      step();
      n_checks++; if (g_grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", g_grant); else n_pass++;
      n_checks++; if (g_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", g_busy); else n_pass++;
      n_checks++; if (g_s_write !== 1'b0) $display("FAIL rst_s_write: got %b want 0", g_s_write); else n_pass++;
      n_checks++; if ({g_m0_wr, g_m1_wr} !== 2'b11) $display("FAIL rst_waitreq: got %b want 11", {g_m0_wr, g_m1_wr}); else n_pass++;
      n_checks++; if (g_err !== 1'b0) $display("FAIL rst_err: got %b want 0", g_err); else n_pass++;
      n_checks++; if ({g_b0, g_b1} !== 32'd0) $display("FAIL rst_bursts: got %h want 0", {g_b0, g_b1}); else n_pass++;
      n_checks++; if (g_be !== 8'hFF) $display("FAIL byteenable: got %h want ff", g_be); else n_pass++;
   endtask

   task automatic test_single_burst();
      int cyc;
      bit m1_ok;
      do_reset();
      m0_address = 29'h100; m0_burstcount = 8'd32; m0_left = 32; m0_bc_model = 32;
      m0_writedata = 64'hA000_0000_0000_0000;
      for (int i = 0; i < 32; i++) exp_q.push_back(64'hA000_0000_0000_0000 + 64'(i));
      m0_write = 1'b1;
      step();
      m1_ok = (g_m1_wr === 1'b1);
      n_checks++; if (g_grant !== 2'b00) $display("FAIL t1_arb_cycle_grant: got %b want 00", g_grant); else n_pass++;
      step();
      n_checks++; if (g_grant !== 2'b01) $display("FAIL t1_grant: got %b want 01", g_grant); else n_pass++;
      n_checks++; if (g_addr !== 29'h100) $display("FAIL t1_address: got %h want 100", g_addr); else n_pass++;
      n_checks++; if (g_bc !== 8'd32) $display("FAIL t1_burstcount: got %0d want 32", g_bc); else n_pass++;
      cyc = 0;
      while (acc0 < 32 && cyc < 200) begin
         step(); cyc++;
         if (g_m1_wr !== 1'b1) m1_ok = 0;
      end
      n_checks++; if (acc0 != 32) $display("FAIL t1_beats: got %0d want 32", acc0); else n_pass++;
      step();
      n_checks++; if (g_grant !== 2'b00) $display("FAIL t1_idle_after: got %b want 00", g_grant); else n_pass++;
      n_checks++; if (g_b0 !== 16'd1) $display("FAIL t1_bursts_m0: got %0d want 1", g_b0); else n_pass++;
      n_checks++; if (!m1_ok) $display("FAIL t1_m1_stalled: got m1_waitrequest low want high"); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL t1_queue: got %0d left want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_contention(input bit fixed);
      int cyc, starts, want_bursts;
      bit order_ok, bubble_ok;
      logic [1:0] prev, want;
      use_fx = fixed;
      do_reset();
      m0_address = 29'h200; m0_burstcount = 8'd4; m0_left = 4; m0_bc_model = 4; m0_rep = 1;
      m1_address = 29'h300; m1_burstcount = 8'd4; m1_left = 4; m1_bc_model = 4; m1_rep = 1;
      m0_writedata = 64'hA100_0000_0000_0000;
      m1_writedata = 64'hB100_0000_0000_0000;
      want_bursts = fixed ? 3 : 8;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 4; i++) exp_q.push_back(64'hA100_0000_0000_0000 + 64'(4 * b + i));
         if (!fixed)
            for (int i = 0; i < 4; i++) exp_q.push_back(64'hB100_0000_0000_0000 + 64'(4 * b + i));
      end
      m0_write = 1'b1; m1_write = 1'b1;
      prev = 2'b00; starts = 0; order_ok = 1; bubble_ok = 1; cyc = 0;
      while ((acc0 + acc1) < 4 * want_bursts && cyc < 300) begin
         step(); cyc++;
         if (g_grant !== 2'b00 && prev === 2'b00) begin
            want = (fixed || starts % 2 == 0) ? 2'b01 : 2'b10;
            if (g_grant !== want) order_ok = 0;
            starts++;
         end
         if (prev !== 2'b00 && g_grant !== 2'b00 && g_grant !== prev) bubble_ok = 0;
         prev = g_grant;
      end
      m0_write = 1'b0; m1_write = 1'b0;
      step();
      n_checks++; if (!order_ok) $display("FAIL t%0d_grant_order: got wrong owner want %s", fixed ? 3 : 2, fixed ? "m0 always" : "alternating"); else n_pass++;
      n_checks++; if (!bubble_ok) $display("FAIL t%0d_bubble: got owner switch without idle want idle cycle", fixed ? 3 : 2); else n_pass++;
      n_checks++; if (starts != want_bursts) $display("FAIL t%0d_starts: got %0d want %0d", fixed ? 3 : 2, starts, want_bursts); else n_pass++;
      if (fixed) begin
         n_checks++; if (g_b0 !== 16'd3 || g_b1 !== 16'd0) $display("FAIL t3_bursts: got %0d/%0d want 3/0", g_b0, g_b1); else n_pass++;
      end else begin
         n_checks++; if (g_b0 !== 16'd4 || g_b1 !== 16'd4) $display("FAIL t2_bursts: got %0d/%0d want 4/4", g_b0, g_b1); else n_pass++;
      end
      use_fx = 0;
      exp_q.delete();
   endtask

   task automatic test_waitrequest();
      int cyc, st3, st6;
      bit mirror_ok;
      do_reset();
      m0_address = 29'h400; m0_burstcount = 8'd8; m0_left = 8; m0_bc_model = 8;
      m0_writedata = 64'hC000_0000_0000_0000;
      for (int i = 0; i < 8; i++) exp_q.push_back(64'hC000_0000_0000_0000 + 64'(i));
      m0_write = 1'b1;
      st3 = 0; st6 = 0; mirror_ok = 1; cyc = 0;
      while (acc0 < 8 && cyc < 100) begin
         s_waitrequest = 1'b0;
         if (acc0 == 2 && st3 < 2) begin s_waitrequest = 1'b1; st3++; end
         else if (acc0 == 5 && st6 < 2) begin s_waitrequest = 1'b1; st6++; end
         step(); cyc++;
         if (g_grant === 2'b01 && g_m0_wr !== s_waitrequest) mirror_ok = 0;
      end
      s_waitrequest = 1'b0;
      step();
      n_checks++; if (acc0 != 8) $display("FAIL t4_beats: got %0d want 8", acc0); else n_pass++;
      n_checks++; if (st3 != 2 || st6 != 2) $display("FAIL t4_stalls: got %0d/%0d want 2/2", st3, st6); else n_pass++;
      n_checks++; if (!mirror_ok) $display("FAIL t4_mirror: got m0_waitrequest differing want equal to s_waitrequest"); else n_pass++;
      n_checks++; if (g_b0 !== 16'd1) $display("FAIL t4_bursts_m0: got %0d want 1", g_b0); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL t4_queue: got %0d left want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_zero_burst();
      int cyc;
      do_reset();
      m1_address = 29'h500; m1_burstcount = 8'd0; m1_left = 1; m1_bc_model = 1;
      m1_writedata = 64'hD000_0000_0000_0000;
      exp_q.push_back(64'hD000_0000_0000_0000);
      m1_write = 1'b1;
      step();
      step();
      n_checks++; if (g_grant !== 2'b10) $display("FAIL t5_grant: got %b want 10", g_grant); else n_pass++;
      n_checks++; if (g_bc !== 8'd1) $display("FAIL t5_burstcount: got %0d want 1", g_bc); else n_pass++;
      step();
      n_checks++; if (acc1 != 1 || g_grant !== 2'b00) $display("FAIL t5_single_beat: got %0d beats grant %b want 1 beat grant 00", acc1, g_grant); else n_pass++;
      n_checks++; if (g_err !== 1'b1) $display("FAIL t5_err_set: got %b want 1", g_err); else n_pass++;
      m0_address = 29'h540; m0_burstcount = 8'd2; m0_left = 2; m0_bc_model = 2;
      m0_writedata = 64'hD100_0000_0000_0000;
      exp_q.push_back(64'hD100_0000_0000_0000);
      exp_q.push_back(64'hD100_0000_0000_0001);
      m0_write = 1'b1;
      cyc = 0;
      while (acc0 < 2 && cyc < 50) begin step(); cyc++; end
      step();
      n_checks++; if (g_b0 !== 16'd1 || g_b1 !== 16'd1) $display("FAIL t5_bursts: got %0d/%0d want 1/1", g_b0, g_b1); else n_pass++;
      n_checks++; if (g_err !== 1'b1) $display("FAIL t5_err_sticky: got %b want 1", g_err); else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      int cyc;
      do_reset();
      m0_address = 29'h600; m0_burstcount = 8'd32; m0_left = 32; m0_bc_model = 32;
      m0_writedata = 64'hE000_0000_0000_0000;
      for (int i = 0; i < 32; i++) exp_q.push_back(64'hE000_0000_0000_0000 + 64'(i));
      m0_write = 1'b1;
      cyc = 0;
      while (acc0 < 10 && cyc < 100) begin step(); cyc++; end
      reset = 1'b1;
      step();
      reset = 1'b0; m0_write = 1'b0;
      exp_q.delete(); acc0 = 0;
      step();
      n_checks++; if (g_s_write !== 1'b0) $display("FAIL t6_s_write: got %b want 0", g_s_write); else n_pass++;
      n_checks++; if (g_grant !== 2'b00) $display("FAIL t6_grant: got %b want 00", g_grant); else n_pass++;
      n_checks++; if (g_b0 !== 16'd0) $display("FAIL t6_bursts_m0: got %0d want 0", g_b0); else n_pass++;
      m0_address = 29'h700; m0_burstcount = 8'd4; m0_left = 4; m0_bc_model = 4;
      m0_writedata = 64'hF000_0000_0000_0000;
      for (int i = 0; i < 4; i++) exp_q.push_back(64'hF000_0000_0000_0000 + 64'(i));
      m0_write = 1'b1;
      step();
      step();
      n_checks++; if (g_grant !== 2'b01 || g_addr !== 29'h700) $display("FAIL t6_regrant: got %b/%h want 01/700", g_grant, g_addr); else n_pass++;
      cyc = 0;
      while (acc0 < 4 && cyc < 50) begin step(); cyc++; end
      step();
      n_checks++; if (g_b0 !== 16'd1) $display("FAIL t6_bursts_after: got %0d want 1", g_b0); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL t6_queue: got %0d left want 0", exp_q.size()); else n_pass++;
   endtask

   initial begin
      n_checks = 0; n_pass = 0; use_fx = 0;
      reset = 1'b1; s_waitrequest = 1'b0;
      m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_burstcount = '0;
      m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_burstcount = '0;
      m0_left = 0; m1_left = 0; m0_bc_model = 0; m1_bc_model = 0; acc0 = 0; acc1 = 0;
      test_reset();
      test_single_burst();
      test_contention(1'b0);
      test_contention(1'b1);
      test_waitrequest();
      test_zero_burst();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
